// File: rtl/operand_sequencer_if.sv
// Instruction request and register-file bus for the operand sequencer.
// slave = sequencer side, master = issuer / register-file side.
interface operand_sequencer_if #(
  parameter int IMM_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [2:0]       req_rd;
  logic [2:0]       req_rn;
  logic [2:0]       req_rm;
  logic [IMM_W-1:0] req_imm;
  logic [1:0]       req_shift;
  logic [2:0]       rf_readnum;
  logic [15:0]      rf_data_out;
  logic [2:0]       rf_writenum;
  logic             rf_write;
  logic [15:0]      rf_data_in;
  logic [2:0]       status;
  logic             done;

  modport slave (
    input  req_valid, req_op, req_rd, req_rn, req_rm, req_imm, req_shift, rf_data_out,
    output req_ready, rf_readnum, rf_writenum, rf_write, rf_data_in, status, done
  );

  modport master (
    output req_valid, req_op, req_rd, req_rn, req_rm, req_imm, req_shift, rf_data_out,
    input  req_ready, rf_readnum, rf_writenum, rf_write, rf_data_in, status, done
  );
endinterface

// File: rtl/operand_sequencer.sv
// Multi-cycle execute controller driving an 8x16 register file through one read port.
// Define OPSEQ_SHIFTER_EN to add the B-operand shifter (LSL1/LSR1/ASR1).
module operand_sequencer #(
  parameter int IMM_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  operand_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ_A, READ_B, EXEC, WB} state_t;

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVN  = 3'b101;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [2:0]       rd_q;
  logic [2:0]       rm_q;
  logic [IMM_W-1:0] imm_q;
  logic [15:0]      a_q;
  logic [15:0]      b_q;
  logic [15:0]      c_q;
  logic [2:0]       status_q;
  logic [2:0]       rf_readnum_q;
  logic [2:0]       rf_writenum_q;
  logic             rf_write_q;
  logic             done_q;

  logic [15:0]      b_operand;
  logic [15:0]      result;
  logic             v_flag;
  logic             status_upd;
  logic             reserved_op;

`ifdef OPSEQ_SHIFTER_EN
  logic [1:0]       shift_q;

  always_comb begin
    b_operand = bus.rf_data_out;
    case (shift_q)
      2'b01:   b_operand = {bus.rf_data_out[14:0], 1'b0};
      2'b10:   b_operand = {1'b0, bus.rf_data_out[15:1]};
      2'b11:   b_operand = {bus.rf_data_out[15], bus.rf_data_out[15:1]};
      default: b_operand = bus.rf_data_out;
    endcase
  end
`else
  logic             unused_shift;

  assign unused_shift = ^bus.req_shift;
  assign b_operand    = bus.rf_data_out;
`endif

  assign reserved_op = (op_q[2:1] == 2'b11);
  assign status_upd  = (op_q == OP_ADD) || (op_q == OP_CMP) ||
                       (op_q == OP_AND) || (op_q == OP_MVN);

  // Overflow: same-sign operands giving a different-sign sum; for A-B the operands differ in sign.
  always_comb begin
    result = c_q;
    v_flag = 1'b0;
    case (op_q)
      OP_MOVI: result = 16'($signed(imm_q));
      OP_MOV:  result = b_q;
      OP_ADD: begin
        result = a_q + b_q;
        v_flag = (a_q[15] == b_q[15]) && (result[15] != a_q[15]);
      end
      OP_CMP: begin
        result = a_q - b_q;
        v_flag = (a_q[15] != b_q[15]) && (result[15] != a_q[15]);
      end
      OP_AND:  result = a_q & b_q;
      OP_MVN:  result = ~b_q;
      default: result = c_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      rm_q          <= '0;
      imm_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      status_q      <= '0;
      rf_readnum_q  <= '0;
      rf_writenum_q <= '0;
      rf_write_q    <= 1'b0;
      done_q        <= 1'b0;
`ifdef OPSEQ_SHIFTER_EN
      shift_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q  <= bus.req_op;
            rd_q  <= bus.req_rd;
            rm_q  <= bus.req_rm;
            imm_q <= bus.req_imm;
`ifdef OPSEQ_SHIFTER_EN
            shift_q <= bus.req_shift;
`endif
            // Read select is set on entry so the combinational read is valid all of READ_A/READ_B.
            if (bus.req_op == OP_MOVI) begin
              state_q <= EXEC;
            end else if (bus.req_op == OP_MOV || bus.req_op == OP_MVN) begin
              state_q      <= READ_B;
              rf_readnum_q <= bus.req_rm;
            end else if (bus.req_op[2:1] == 2'b11) begin
              state_q <= EXEC;
              done_q  <= 1'b1;
            end else begin
              state_q      <= READ_A;
              rf_readnum_q <= bus.req_rn;
            end
          end
        end
        READ_A: begin
          a_q          <= bus.rf_data_out;
          rf_readnum_q <= rm_q;
          state_q      <= READ_B;
        end
        READ_B: begin
          b_q     <= b_operand;
          state_q <= EXEC;
          if (op_q == OP_CMP) begin
            done_q <= 1'b1;
          end
        end
        EXEC: begin
          c_q <= result;
          if (status_upd) begin
            status_q <= {result[15], v_flag, (result == 16'h0000)};
          end
          if (op_q == OP_CMP || reserved_op) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else begin
            state_q       <= WB;
            rf_write_q    <= 1'b1;
            done_q        <= 1'b1;
            rf_writenum_q <= rd_q;
          end
        end
        WB: begin
          rf_write_q <= 1'b0;
          done_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          rf_write_q <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rf_readnum  = rf_readnum_q;
  assign bus.rf_writenum = rf_writenum_q;
  assign bus.rf_write    = rf_write_q;
  assign bus.rf_data_in  = c_q;
  assign bus.status      = status_q;
  assign bus.done        = done_q;

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
Multi-cycle execute controller that sits directly on the 8x16 register file (8 registers, one combinational read port, one synchronous write port). It accepts one instruction per handshake, sequences register reads through the single read port into operand latches A/B, computes a 16-bit ALU result, writes it back, and updates status flags. It is the sole driver of the register file's readnum, writenum, write and data_in.

Parameters:
IMM_W, 8, width of immediate field; sign-extended to 16 bits.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  instruction offered
req_ready  out  1  block can accept; high only in IDLE
req_op  in  3  000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 11x reserved
req_rd  in  3  destination register
req_rn  in  3  first source register
req_rm  in  3  second source register
req_imm  in  IMM_W  immediate for MOVI
req_shift  in  2  B-operand shift (optional feature only)
rf_readnum  out  3  register file read select
rf_data_out  in  16  register file read data (combinational from rf_readnum)
rf_writenum  out  3  register file write select
rf_write  out  1  register file write enable
rf_data_in  out  16  write-back data
status  out  3  {N, V, Z}
done  out  1  one-cycle pulse at instruction completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; A, B, C, status = 0; rf_write=0, done=0, rf_readnum=0, rf_writenum=0, rf_data_in=0; latched fields = 0. Reset mid-instruction aborts it with no write-back and no done.
- States: IDLE, READ_A, READ_B, EXEC, WB.
- IDLE: req_ready=1. On req_valid=1 latch op/rd/rn/rm/imm/shift. Next state: MOVI -> EXEC; MOV, MVN -> READ_B; all others -> READ_A. Reserved ops are accepted, complete as no-ops (IDLE -> EXEC, done pulse in EXEC, no write-back, status unchanged).
- READ_A: rf_readnum=rn; A <= rf_data_out at cycle end -> READ_B.
- READ_B: rf_readnum=rm; B <= shift(rf_data_out) -> EXEC.
- EXEC: C <= result. ADD: A+B. CMP: A-B. AND: A&B. MVN: ~B. MOV: B. MOVI: sign-extended imm. All arithmetic is 16-bit modulo; carry is dropped.
- Status is written in EXEC for ADD, CMP, AND and MVN only; MOV and MOVI leave it unchanged. Z = (result==0), N = result[15], V = signed overflow (ADD, CMP), V=0 for AND and MVN.
- CMP and reserved ops: done=1 in EXEC, then IDLE, no WB.
- Other ops: EXEC -> WB. In WB: rf_write=1, rf_writenum=rd, rf_data_in=C, done=1; the register file captures on the WB->IDLE edge.
- Outputs are registered/decoded from state; rf_write is never high outside WB.
- Latency from the accept edge to the done cycle: MOVI 2, MOV/MVN 3, ADD/AND 4, CMP 3. Back-to-back: req_ready returns high the cycle after done. Minimum issue interval = latency + 1.
- rd equal to rn or rm is legal: reads complete before WB, so the next instruction sees the new value.
- Inputs other than req_valid are sampled only at the accept edge; changes afterwards are ignored.
- rf_readnum holds its last value in IDLE, EXEC and WB.

Optional Feature:
OPSEQ_SHIFTER_EN
- Defined: B = rf_data_out shifted per req_shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (sign fill). Applies to MOV, ADD, CMP, AND, MVN.
- Undefined: req_shift is ignored; B = rf_data_out unshifted; no shifter logic is present.

Test Plan:
- Reset: assert rst_n=0 mid-ADD (in READ_B) -> immediately IDLE, status=000, rf_write=0, no done pulse, and the register file is untouched.
- MOVI rd=3 imm=8'hF0 -> done 2 cycles after accept, R3=16'hFFF0 written in WB, status unchanged.
- ADD: R1=16'h7FFF, R2=16'h0001, ADD rd=0 rn=1 rm=2 -> R0=16'h8000, N=1 V=1 Z=0, done at cycle 4.
- CMP: R4=R5=16'h1234 -> Z=1 N=0 V=0, rf_write never asserted, done at cycle 3.
- Hazard/back-to-back: ADD rd=1 rn=1 rm=1 with R1=5, then MOV rd=2 rm=1 with req_valid held high -> R1=10, then R2=10, second accept the cycle after the first done.
- With OPSEQ_SHIFTER_EN: MOV rd=6 rm=7 shift=11, R7=16'h8004 -> R6=16'hC002; without the macro the same stimulus gives R6=16'h8004.
